// File: rtl/divider_sched.sv
// Round-robin scheduler sharing one clock divider among NREQ requesters.
// Each granted job gets a gated run_clk of exactly `cycles` full divider periods.
module divider_sched #(
  parameter int WIDTH  = 24,
  parameter int NREQ   = 4,
  parameter int CWIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_load,
  input  logic [NREQ*CWIDTH-1:0]   req_cycles,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [WIDTH-1:0]         div_load,
  input  logic                     div_clk,
  output logic                     run_clk
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, win;
  logic              win_vld;
  logic [WIDTH-1:0]  win_load;
  logic [CWIDTH-1:0] win_cycles, cycles_q;
  logic [CWIDTH:0]   tgl_cnt, cnt_inc;
  logic              div_clk_q, phase, arm_entry, run_entry;
  logic              toggle, last_toggle;

  assign toggle      = div_clk ^ div_clk_q;
  assign cnt_inc     = tgl_cnt + {{CWIDTH{1'b0}}, 1'b1};
  assign last_toggle = toggle && !run_entry && (cnt_inc == {cycles_q, 1'b0});
  assign busy        = (state != IDLE);
  // The RUN entry cycle is forced low; afterwards phase aligns run_clk to start low.
  assign run_clk     = (state == RUN) && !run_entry && (div_clk ^ phase);

  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
    win_load   = req_load[int'(win)*WIDTH +: WIDTH];
    win_cycles = req_cycles[int'(win)*CWIDTH +: CWIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = (win_cycles == '0) ? DONE : ARM;
      ARM:     if (toggle && !arm_entry) state_nxt = RUN;
      RUN:     if (last_toggle) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      gnt       <= '0;
      done      <= '0;
      div_load  <= '1;
      ptr       <= '0;
      cycles_q  <= '0;
      tgl_cnt   <= '0;
      phase     <= 1'b0;
      div_clk_q <= 1'b0;
      arm_entry <= 1'b0;
      run_entry <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
      done      <= '0;
      arm_entry <= 1'b0;
      run_entry <= 1'b0;
      case (state)
        IDLE: if (win_vld) begin
          gnt      <= NREQ'(1) << win;
          cycles_q <= win_cycles;
          ptr      <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
          if (win_cycles != '0) begin
            div_load  <= win_load;
            arm_entry <= 1'b1;
          end else begin
            done <= NREQ'(1) << win;
          end
        end
        ARM: if (toggle && !arm_entry) begin
          tgl_cnt   <= '0;
          run_entry <= 1'b1;
        end
        RUN: begin
          if (run_entry) phase <= div_clk;
          else if (toggle) tgl_cnt <= cnt_inc;
          if (last_toggle) done <= gnt;
        end
        DONE: gnt <= '0;
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/divider_sched.md
DIVIDER_SCHED -- requirements
Module: divider_sched

Interface
REQ-001 Parameter WIDTH, default 24: width of divider load values; matches the divider load port.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-003 Parameter CWIDTH, default 16: width of per-request output period count.
REQ-004 clk_in  input  1  sole clock; all logic on posedge clk_in.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request level; bit i belongs to requester i.
REQ-007 req_load  input  NREQ*WIDTH  divider load for requester i, at bits [i*WIDTH +: WIDTH].
REQ-008 req_cycles  input  NREQ*CWIDTH  number of full output periods for requester i, at bits [i*CWIDTH +: CWIDTH].
REQ-009 gnt  output  NREQ  one-hot grant, held from acceptance until done.
REQ-010 done  output  NREQ  one-cycle completion pulse for the granted requester.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 div_load  output  WIDTH  registered load value driven to the shared divider.
REQ-013 div_clk  input  1  divider output; generated in the clk_in domain, so no synchroniser is used.
REQ-014 run_clk  output  1  gated divided clock delivered to the granted requester.

Function
REQ-015 States: IDLE, ARM, RUN, DONE; state, gnt, done, div_load and the edge register div_clk_q are registered.
REQ-016 Toggle detection: toggle = div_clk XOR div_clk_q; div_clk_q <= div_clk every cycle.
REQ-017 IDLE, some req bit high: round-robin pick.
- Search starts at the priority pointer and wraps.
- Latch req_load and req_cycles of the winner.
- gnt one-hot on the next cycle.
REQ-018 Priority pointer: after each grant to i, pointer becomes (i+1) mod NREQ.
REQ-019 Zero cycles: if latched cycles = 0, go IDLE -> DONE directly; div_load is unchanged and no RUN occurs.
REQ-020 On entry to ARM, div_load takes the latched load value.
REQ-021 ARM: ignore any toggle in the ARM entry cycle; the first toggle in a later ARM cycle moves to RUN.
REQ-022 RUN entry: latch phase = div_clk in that cycle.
REQ-023 RUN toggle counting: internal counter of CWIDTH+1 bits, target 2*cycles.
REQ-024 RUN exit: on the toggle that reaches the count, go to DONE.
REQ-025 run_clk = div_clk XOR phase while in RUN, else 0.
- run_clk is low at RUN entry and low at RUN exit.
- run_clk delivers exactly cycles full periods of 2*(load+1) clk_in cycles each.
REQ-026 DONE lasts exactly one cycle.
- done[i] = 1 and gnt[i] = 1 in DONE.
- DONE -> IDLE; gnt clears on that transition.
- A new grant is possible no earlier than the cycle after IDLE is re-entered.
REQ-027 Dropping req[i] while granted has no effect: the job completes and done[i] still pulses.
REQ-028 Changes to req_load or req_cycles after acceptance are ignored.
REQ-029 Simultaneous requests: exactly one grant per arbitration; losers stay pending.
REQ-030 div_load holds its last value in IDLE, DONE and after completion.
REQ-031 busy = (state != IDLE).

Reset
REQ-032 Reset has priority over all other events.
- State goes to IDLE.
- gnt = 0, done = 0, run_clk = 0, busy = 0.
- div_load = all ones, parking the divider at its slowest rate.
- Priority pointer = 0; toggle counter = 0; phase = 0; div_clk_q = 0.
REQ-033 Reset asserted mid-ARM or mid-RUN:
- Job is abandoned without a done pulse.
- run_clk goes low on the cycle after reset is sampled.

Verification (bench instantiates the divider with load = div_load and div_clk = its clk_out)
REQ-034 Single request: req = 0001, load = 3, cycles = 2 -> gnt = 0001 one cycle later; run_clk gives 2 periods of 8 clk_in cycles (4 high, 4 low); done[0] is a one-cycle pulse; busy drops the next cycle.
REQ-035 Contention: req = 1111 held, pointer 0 -> grants issued in order 0, 1, 2, 3, 0; no overlap between gnt bits; each done matches its gnt.
REQ-036 Zero cycles: req = 0100, cycles = 0 -> gnt[2] for one cycle, then done[2] in DONE; run_clk stays 0; div_load unchanged.
REQ-037 Load change between jobs: job A load = 1, cycles = 3, then job B load = 5, cycles = 1 -> A gives 3 periods of 4 clk_in cycles; B gives 1 period of 12 clk_in cycles; no short run_clk pulse at the boundary.
REQ-038 Reset mid-RUN: assert reset after 3 toggles of a cycles = 4 job -> no done pulse; run_clk = 0; div_load = all ones; a following req = 0010 is granted to requester 1 with the pointer at 0.
REQ-039 Request drop: deassert req[1] during RUN -> job still completes with the full cycles count and done[1] pulses.
